// File: rtl/alu_pkg.sv
// Shared ALU op encoding, write-back select encoding and buffered result entry layout.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [SEL_W-1:0] {
    WB_GPR = 2'b00,
    WB_LO  = 2'b01,
    WB_HI  = 2'b10
  } wb_sel_e;

  // One ALU result as held in the FIFO (destination kept alongside, width is per-instance)
  typedef struct packed {
    alu_op_e             op;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                b_zero;
  } alu_res_t;

  localparam int unsigned RES_W = $bits(alu_res_t);

  // MUL/DIV produce a LO beat followed by a HI beat
  function automatic logic is_two_beat(alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // A DIV by zero is dropped without any write beats
  function automatic logic is_div_zero(alu_res_t r);
    return (r.op == OP_DIV) && r.b_zero;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small power-of-two FIFO exposing the head and the entry behind it.
module result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             head_c,
  output logic [W-1:0]             next_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_ok = push_i & ~full_c;
  assign pop_ok  = pop_i & ~empty_c;
  assign head_c  = mem_q[rptr_q];
  assign next_c  = mem_q[rptr_q + PTR_W'(1)];
  assign count_o = count_q;

  // Pointer/count next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) wptr_d = wptr_q + PTR_W'(1);
    if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
  end

  // Storage array; contents are only meaningful under the count
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_result_writeback.sv
// Buffers ALU results and sequences them as GPR or LO/HI write beats.
module alu_result_writeback
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [DATA_W-1:0]   in_hi,
  input  logic [DATA_W-1:0]   in_lo,
  input  logic [ADDR_W-1:0]   in_dest,
  input  logic                in_b_zero,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [SEL_W-1:0]    wb_sel,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                div_zero,
  input  logic                div_zero_clr,
  output logic                busy
);

  localparam int unsigned ENT_W = RES_W + ADDR_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BEAT_LO = 2'b01,
    ST_BEAT_HI = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               wb_valid_q, wb_valid_d;
  wb_sel_e            wb_sel_q, wb_sel_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               div_zero_q, div_zero_d;

  alu_res_t           in_res, head_res, next_res, cand_res;
  logic [ADDR_W-1:0]  head_dest, next_dest, cand_dest;
  logic [ENT_W-1:0]   head_raw, next_raw;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               has_next, accept;
  logic               pop_c, dz_set_c, chain_c, load_lo_c;

  assign in_res = '{op: alu_op_e'(in_op), hi: in_hi, lo: in_lo, b_zero: in_b_zero};

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (in_valid),
    .pop_i   (pop_c),
    .wdata_i ({in_res, in_dest}),
    .head_c  (head_raw),
    .next_c  (next_raw),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_res  = head_raw[ENT_W-1:ADDR_W];
  assign head_dest = head_raw[ADDR_W-1:0];
  assign next_res  = next_raw[ENT_W-1:ADDR_W];
  assign next_dest = next_raw[ADDR_W-1:0];

  // From IDLE the head is loaded; after a pop the entry behind it is loaded
  assign cand_res  = (state_q == ST_IDLE) ? head_res  : next_res;
  assign cand_dest = (state_q == ST_IDLE) ? head_dest : next_dest;

  assign has_next = (fifo_count > CNT_W'(1));
  assign accept   = wb_valid_q & wb_ready;

  assign in_ready = ~fifo_full;
  assign busy     = (fifo_count != '0) | wb_valid_q;
  assign wb_valid = wb_valid_q;
  assign wb_sel   = wb_sel_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign div_zero = div_zero_q;

  // Drain FSM: next state, pop strobe and next output beat
  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_sel_d   = wb_sel_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    pop_c      = 1'b0;
    dz_set_c   = 1'b0;
    chain_c    = 1'b0;
    load_lo_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_div_zero(head_res)) begin
            pop_c    = 1'b1;
            dz_set_c = 1'b1;
          end else begin
            load_lo_c = 1'b1;
          end
        end
      end
      ST_BEAT_LO: begin
        if (accept) begin
          if (is_two_beat(head_res.op)) begin
            state_d   = ST_BEAT_HI;
            wb_sel_d  = WB_HI;
            wb_addr_d = '0;
            wb_data_d = head_res.hi;
          end else begin
            pop_c   = 1'b1;
            chain_c = 1'b1;
          end
        end
      end
      ST_BEAT_HI: begin
        if (accept) begin
          pop_c   = 1'b1;
          chain_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Back-to-back: present the following entry without an idle bubble
    if (chain_c) begin
      if (has_next && !is_div_zero(next_res)) begin
        load_lo_c = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        wb_valid_d = 1'b0;
        wb_sel_d   = WB_GPR;
        wb_addr_d  = '0;
        wb_data_d  = '0;
      end
    end

    if (load_lo_c) begin
      state_d    = ST_BEAT_LO;
      wb_valid_d = 1'b1;
      wb_sel_d   = is_two_beat(cand_res.op) ? WB_LO : WB_GPR;
      wb_addr_d  = is_two_beat(cand_res.op) ? '0 : cand_dest;
      wb_data_d  = cand_res.lo;
    end

    div_zero_d = dz_set_c | (div_zero_q & ~div_zero_clr);
  end

  // State and registered write-port outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= WB_GPR;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Bench for alu_result_writeback: vector table, corner sequences, random stream vs queue model.
module tb_alu_result_writeback;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_hi;
  logic [31:0] in_lo;
  logic [3:0]  in_dest;
  logic        in_b_zero;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_sel;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        div_zero;
  logic        div_zero_clr;
  logic        busy;

  alu_result_writeback #(.DEPTH(2), .ADDR_W(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_hi        (in_hi),
    .in_lo        (in_lo),
    .in_dest      (in_dest),
    .in_b_zero    (in_b_zero),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_sel       (wb_sel),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .div_zero     (div_zero),
    .div_zero_clr (div_zero_clr),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass;
  int n_total;
  int n_beats;
  logic last_pushed;
  logic dz_model;
  logic [37:0] exp_q[$];   // expected beats {sel, addr, data} in write order

  typedef struct {
    logic [1:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  dest;
    logic        bz;
    int          nb;
    logic [37:0] b0;
    logic [37:0] b1;
    logic        dz;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  // Reference behaviour: each accepted result expands into its list of write beats
  task automatic model_push(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo,
                            input logic [3:0] dest, input logic bz);
    if (op == 2'd3 && bz) dz_model = 1'b1;
    else if (op == 2'd0 || op == 2'd1) exp_q.push_back({2'b00, dest, lo});
    else begin
      exp_q.push_back({2'b01, 4'h0, lo});
      exp_q.push_back({2'b10, 4'h0, hi});
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [3:0] dest, input logic bz);
    in_valid  = 1'b1;
    in_op     = op;
    in_hi     = hi;
    in_lo     = lo;
    in_dest   = dest;
    in_b_zero = bz;
  endtask

  task automatic rand_drive();
    logic [1:0] op;
    op = 2'($urandom_range(3, 0));
    drive(op, $urandom, $urandom, 4'($urandom_range(15, 0)),
          (op == 2'd3) ? ($urandom_range(5, 0) == 0) : 1'($urandom_range(1, 0)));
  endtask

  // One clock: sample handshakes before the edge, update model and check after it
  task automatic tick();
    logic push_now, acc_now, hold_now;
    logic [37:0] held;
    logic [1:0]  op;
    logic [31:0] hi, lo;
    logic [3:0]  dest;
    logic        bz;
    push_now = in_valid && in_ready;
    acc_now  = wb_valid && wb_ready;
    hold_now = wb_valid && !wb_ready;
    held     = {wb_sel, wb_addr, wb_data};
    op = in_op; hi = in_hi; lo = in_lo; dest = in_dest; bz = in_b_zero;
    @(posedge clock);
    #1;
    last_pushed = push_now;
    if (push_now) model_push(op, hi, lo, dest, bz);
    if (acc_now) begin
      n_beats++;
      if (exp_q.size() == 0) fail_now("beat_unexpected");
      else chk("beat_order", 64'(held), 64'(exp_q.pop_front()));
    end
    if (hold_now) chk("beat_hold", 64'({wb_valid, wb_sel, wb_addr, wb_data}), 64'({1'b1, held}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb0;
    int pushes;
    n_pass = 0; n_total = 0; n_beats = 0;
    last_pushed = 1'b0; dz_model = 1'b0;

    //            op     hi            lo            dest   bz   nb  beat0                        beat1                        dz
    vt[0] = '{2'd0, 32'h1,        32'h5,        4'd3,  1'b0, 1, {2'b00, 4'd3,  32'h5},        38'h0,                       1'b0};
    vt[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'd15, 1'b0, 1, {2'b00, 4'd15, 32'hFFFFFFFE}, 38'h0,                       1'b0};
    vt[2] = '{2'd2, 32'h2,        32'h10,       4'd7,  1'b0, 2, {2'b01, 4'd0,  32'h10},       {2'b10, 4'd0, 32'h2},        1'b0};
    vt[3] = '{2'd3, 32'h3,        32'h21,       4'd9,  1'b0, 2, {2'b01, 4'd0,  32'h21},       {2'b10, 4'd0, 32'h3},        1'b0};
    vt[4] = '{2'd3, 32'h44,       32'h55,       4'd2,  1'b1, 0, 38'h0,                        38'h0,                       1'b1};
    vt[5] = '{2'd0, 32'h0,        32'hDEADBEEF, 4'd0,  1'b1, 1, {2'b00, 4'd0,  32'hDEADBEEF}, 38'h0,                       1'b0};

    reset_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_hi = '0; in_lo = '0; in_dest = '0;
    in_b_zero = 1'b0; wb_ready = 1'b0; div_zero_clr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_flags", 64'({wb_valid, busy, div_zero}), 64'(0));
    chk("reset_beat_regs", 64'({wb_sel, wb_addr, wb_data}), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single-result vectors from idle with the write port always ready
    for (int i = 0; i < 6; i++) begin
      div_zero_clr = 1'b1;
      tick();
      div_zero_clr = 1'b0;
      dz_model = 1'b0;
      drive(vt[i].op, vt[i].hi, vt[i].lo, vt[i].dest, vt[i].bz);
      wb_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(1));
      for (int b = 0; b < vt[i].nb; b++) begin
        tick();
        chk($sformatf("v%0d_beat%0d", i, b), 64'({wb_valid, wb_sel, wb_addr, wb_data}),
            64'({1'b1, (b == 0) ? vt[i].b0 : vt[i].b1}));
      end
      tick();
      chk($sformatf("v%0d_done", i), 64'({wb_valid, busy, div_zero}), 64'({2'b00, vt[i].dz}));
    end

    // Sticky divide-by-zero, set winning over a simultaneous clear
    drive(2'd3, 32'h9, 32'h8, 4'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("dz_set", 64'(div_zero), 64'(1));
    tick(); tick();
    chk("dz_sticky", 64'({wb_valid, div_zero}), 64'({1'b0, 1'b1}));
    drive(2'd3, 32'h7, 32'h6, 4'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    div_zero_clr = 1'b1;
    tick();
    chk("dz_set_wins", 64'(div_zero), 64'(1));
    tick();
    chk("dz_clr", 64'(div_zero), 64'(0));
    div_zero_clr = 1'b0;
    dz_model = 1'b0;

    // Backpressure: two results fill the FIFO, the third waits for a free slot
    wb_ready = 1'b0;
    nb0 = n_beats;
    drive(2'd0, 32'h0, 32'h111, 4'd1, 1'b0);
    chk("bp_ready_empty", 64'(in_ready), 64'(1));
    tick();
    drive(2'd1, 32'h0, 32'h222, 4'd2, 1'b0);
    tick();
    chk("bp_full", 64'(in_ready), 64'(0));
    chk("bp_head", 64'({wb_valid, wb_sel, wb_addr, wb_data}), 64'({1'b1, 2'b00, 4'd1, 32'h111}));
    drive(2'd2, 32'h3, 32'h333, 4'd5, 1'b0);
    repeat (3) tick();
    chk("bp_refused", 64'({in_ready, last_pushed}), 64'(0));
    wb_ready = 1'b1;
    tick();
    chk("bp_nobypass", 64'(last_pushed), 64'(0));
    chk("bp_next", 64'({wb_valid, wb_sel, wb_addr, wb_data}), 64'({1'b1, 2'b00, 4'd2, 32'h222}));
    chk("bp_slot_free", 64'(in_ready), 64'(1));
    for (int k = 0; k < 30; k++) begin
      tick();
      if (last_pushed) in_valid = 1'b0;
      if (!in_valid && !busy) break;
    end
    chk("bp_drained", 64'({in_valid, busy}), 64'(0));
    chk("bp_beats", 64'(n_beats - nb0), 64'(4));
    chk("bp_queue", 64'(exp_q.size()), 64'(0));

    // Reset while a MUL HI beat is stalled and another result is queued
    wb_ready = 1'b1;
    drive(2'd2, 32'hAA, 32'hBB, 4'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_in_hi", 64'({wb_valid, wb_sel, wb_data}), 64'({1'b1, 2'b10, 32'hAA}));
    wb_ready = 1'b0;
    drive(2'd0, 32'h0, 32'hCC, 4'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_async", 64'({wb_valid, busy, in_ready}), 64'({1'b0, 1'b0, 1'b1}));
    exp_q.delete();
    dz_model = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_replay", 64'({wb_valid, busy}), 64'(0));
    end

    // Random stream against the queue model
    pushes = 0;
    rand_drive();
    for (int cyc = 0; cyc < 6000 && pushes < 160; cyc++) begin
      wb_ready = ($urandom_range(2, 0) != 0);
      tick();
      if (last_pushed) begin
        pushes++;
        if (pushes < 160 && $urandom_range(3, 0) != 0) rand_drive();
        else in_valid = 1'b0;
      end else if (!in_valid && pushes < 160 && $urandom_range(1, 0) == 1) begin
        rand_drive();
      end
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!busy) break;
      tick();
    end
    chk("rnd_pushes", 64'(pushes), 64'(160));
    chk("rnd_drained", 64'({busy, wb_valid}), 64'(0));
    chk("rnd_queue", 64'(exp_q.size()), 64'(0));
    chk("rnd_div_zero", 64'(div_zero), 64'(dz_model));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
